// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: eight-phase instruction sequencer for the accumulator CPU.
// Each instruction takes phases S0..S7. S0/S1 fetch two bytes, S3 may halt,
// and S4..S6 perform the opcode-specific memory, accumulator or PC work.
// The strobes are decoded combinationally from the phase, the halted flag,
// the opcode and the zero flag. The run enable and reset act as gates.

module cpu_seq_ctrl (
    input  logic       clk1,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       rd,
    output logic       wr,
    output logic       load_acc,
    output logic       load_pc,
    output logic       datactl_ena,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } state_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    state_t state;
    logic   halted;
    logic   alu_op;

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

    assign phase = state;

    // Phase counter and halt latch. Once halted, the sequencer parks at S3 until reset.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state  <= S0;
            halted <= 1'b0;
        end else if (halted) begin
            state  <= state;
        end else if (!ena) begin
            state  <= S0;
        end else if ((state == S3) && (opcode == OP_HLT)) begin
            halted <= 1'b1;
        end else begin
            state  <= state_t'(state + 3'd1);
        end
    end

    // Strobe decode. Reset and run enable gate the strobes combinationally so they drop without a clock.
    always_comb begin
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        load_acc    = 1'b0;
        load_pc     = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;
        if (!rst) begin
            halt = 1'b0;
        end else if (halted) begin
            halt = 1'b1;
        end else if (ena) begin
            case (state)
                S0, S1: begin
                    load_ir = 1'b1;
                    rd      = 1'b1;
                    inc_pc  = 1'b1;
                end
                S3: begin
                    halt = (opcode == OP_HLT);
                end
                S4: begin
                    rd          = alu_op;
                    datactl_ena = (opcode == OP_STO);
                    load_pc     = (opcode == OP_JMP);
                    inc_pc      = (opcode == OP_SKZ) && zero;
                end
                S5: begin
                    rd          = alu_op;
                    load_acc    = alu_op;
                    wr          = (opcode == OP_STO);
                    datactl_ena = (opcode == OP_STO);
                    load_pc     = (opcode == OP_JMP);
                    inc_pc      = (opcode == OP_SKZ) && zero;
                end
                S6: begin
                    datactl_ena = (opcode == OP_STO);
                end
                default: begin
                    halt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: directed and randomized checks of the instruction sequencer
// against a behavioural model of the phase/strobe rules.

module tb_cpu_seq_ctrl;

    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] LDA = 3'b101;
    localparam logic [2:0] STO = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    logic       clk1 = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic       zero = 1'b0;
    logic       load_ir, inc_pc, rd, wr, load_acc, load_pc, datactl_ena, halt;
    logic [2:0] phase;

    int         checks = 0;
    int         errors = 0;
    int         m_step = 0;
    bit         m_halted = 1'b0;
    logic [7:0] last_obs;

    cpu_seq_ctrl dut (
        .clk1        (clk1),
        .rst         (rst),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .rd          (rd),
        .wr          (wr),
        .load_acc    (load_acc),
        .load_pc     (load_pc),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .phase       (phase)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk1 = ~clk1;

    // Expected strobes {load_ir,inc_pc,rd,wr,load_acc,load_pc,datactl_ena,halt} for one instruction step.
    function automatic logic [7:0] model_exp(input int step, input bit hlt_f, input logic e,
                                             input logic r, input logic [2:0] op, input logic z);
        bit li = 0, ip = 0, rdv = 0, wrv = 0, la = 0, lp = 0, dc = 0, h = 0;
        bit is_alu = (op == ADD) || (op == 3'b011) || (op == 3'b100) || (op == LDA);
        if (!r) return 8'h00;
        if (hlt_f) return 8'h01;
        if (!e) return 8'h00;
        if (step < 2) begin
            li = 1; ip = 1; rdv = 1;
        end
        if (step == 3 && op == HLT) h = 1;
        if (step == 4 || step == 5) begin
            rdv = is_alu;
            lp  = (op == JMP);
            ip  = (op == SKZ) && z;
            dc  = (op == STO);
        end
        if (step == 5) begin
            la  = is_alu;
            wrv = (op == STO);
        end
        if (step == 6) dc = (op == STO);
        return {li, ip, rdv, wrv, la, lp, dc, h};
    endfunction

    // Advance the model across one rising edge.
    task automatic model_edge();
        if (!rst) begin
            m_step = 0; m_halted = 0;
        end else if (m_halted) begin
            m_step = m_step;
        end else if (!ena) begin
            m_step = 0;
        end else if (m_step == 3 && opcode == HLT) begin
            m_halted = 1;
        end else begin
            m_step = (m_step + 1) % 8;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] obs;
        logic [7:0] exp;
        logic [2:0] exp_phase;
        obs = {load_ir, inc_pc, rd, wr, load_acc, load_pc, datactl_ena, halt};
        exp = model_exp(m_step, m_halted, ena, rst, opcode, zero);
        exp_phase = 3'(m_step);
        last_obs = obs;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s strobes observed=%b expected=%b", tag, obs, exp);
        end
        checks++;
        assert (phase === exp_phase) else begin
            errors++;
            $error("[TB] FAIL %s phase observed=%0d expected=%0d", tag, phase, exp_phase);
        end
        checks++;
        assert ((rd && wr) === 1'b0 && (wr && !datactl_ena) === 1'b0) else begin
            errors++;
            $error("[TB] FAIL %s rd/wr/datactl observed=%b%b%b expected no rd+wr, no wr without datactl",
                   tag, rd, wr, datactl_ena);
        end
    endtask

    // One clock: drive inputs just after the edge, check mid-cycle, then step the model at the edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [2:0] op,
                                 input logic z, input string tag);
        rst = r; ena = e; opcode = op; zero = z;
        if (!r) begin
            m_step = 0; m_halted = 0;
        end
        #3;
        checkOutput(tag);
        @(posedge clk1);
        model_edge();
        #1;
    endtask

    // A complete 8-cycle instruction with run enable held high; returns the inc_pc pulse count.
    task automatic run_instr(input logic [2:0] op, input logic z, input string tag, output int inc_cnt);
        inc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, op, z, tag);
            inc_cnt += int'(last_obs[6]);
        end
    endtask

    // Run to S5 of an instruction and assert reset between edges.
    task automatic mid_reset(input logic [2:0] op, input string tag);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, op, 1'b0, tag);
        rst = 1'b1; ena = 1'b1; opcode = op; zero = 1'b0;
        #3;
        checkOutput(tag);
        #2;
        rst = 1'b0;
        m_step = 0; m_halted = 0;
        #1;
        checkOutput({tag, "_async"});
        @(posedge clk1);
        model_edge();
        #1;
        applyStimulus(1'b0, 1'b1, op, 1'b0, {tag, "_held"});
        applyStimulus(1'b1, 1'b1, LDA, 1'b0, {tag, "_resume"});
    endtask

    initial begin
        int cnt;
        logic [2:0] rop;

        #1 rst = 1'b0;
        ena = 1'b1;
        #1;
        checkOutput("reset_state");
        @(posedge clk1);
        #1;

        run_instr(LDA, 1'b0, "lda", cnt);
        run_instr(STO, 1'b0, "sto", cnt);

        run_instr(SKZ, 1'b1, "skz_z1", cnt);
        checks++;
        assert (cnt === 4) else begin
            errors++;
            $error("[TB] FAIL skz_z1_count observed=%0d expected=4", cnt);
        end
        run_instr(SKZ, 1'b0, "skz_z0", cnt);
        checks++;
        assert (cnt === 2) else begin
            errors++;
            $error("[TB] FAIL skz_z0_count observed=%0d expected=2", cnt);
        end

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, JMP, 1'b0, "jmp");
        applyStimulus(1'b1, 1'b0, JMP, 1'b0, "jmp_ena_off");
        applyStimulus(1'b1, 1'b0, JMP, 1'b0, "jmp_idle");
        applyStimulus(1'b1, 1'b0, JMP, 1'b0, "jmp_idle");
        run_instr(JMP, 1'b0, "jmp_restart", cnt);

        mid_reset(ADD, "add_reset");
        run_instr(STO, 1'b0, "sto_full", cnt);
        mid_reset(STO, "sto_reset");

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, HLT, 1'b0, "hlt");
        for (int i = 0; i < 22; i++)
            applyStimulus(1'b1, 1'($urandom), 3'($urandom), 1'($urandom), "halted");
        applyStimulus(1'b0, 1'b1, LDA, 1'b0, "hlt_reset");
        applyStimulus(1'b1, 1'b1, LDA, 1'b0, "hlt_release");

        rop = LDA;
        for (int i = 0; i < 600; i++) begin
            if (m_step == 0) begin
                rop = 3'($urandom_range(1, 7));
                if ($urandom_range(0, 15) == 0) rop = HLT;
            end
            if (m_halted && $urandom_range(0, 5) == 0)
                applyStimulus(1'b0, 1'($urandom), rop, 1'($urandom), "rand_reset");
            else
                applyStimulus(1'b1, 1'($urandom_range(0, 9) != 0), rop, 1'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_seq_ctrl.md
CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 The block SHALL have the port clk1, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port ena, input, 1 bit: sequencer run enable, from the clock generator fetch phase.
REQ-004 The block SHALL have the port opcode, input, 3 bits: instruction register bits [15:13].
REQ-005 The block SHALL have the port zero, input, 1 bit: accumulator-equals-zero flag.
REQ-006 The block SHALL have the outputs load_ir, inc_pc, rd, wr, load_acc, load_pc, datactl_ena and halt, each 1 bit: datapath strobes.
REQ-007 The block SHALL have the port phase, output, 3 bits: current sequencer state S0..S7, for debug.
REQ-008 The block SHALL use these opcode encodings: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111; ALU-class = ADD, AND, XOR, LDA.

Function
REQ-009 The block SHALL hold its state in a single 3-bit register plus a 1-bit halted flag; all outputs SHALL be combinational decodes of state, halted, opcode and zero.
REQ-010 While ena=1 and halted=0, the state SHALL advance S0->S1->...->S7->S0, one state per clk1 edge; one instruction takes 8 cycles.
REQ-011 While ena=0, the state SHALL load S0 at the next edge and all strobes SHALL be 0 in that cycle; halted SHALL be unaffected.
REQ-012 In S0 and S1, the block SHALL drive load_ir=1, rd=1 and inc_pc=1, fetching the high byte and then the low byte of the instruction.
REQ-013 In S2, all strobes SHALL be 0.
REQ-014 In S3 with opcode=HLT, the block SHALL drive halt=1 and set halted at the edge; otherwise all strobes SHALL be 0 in S3.
REQ-015 In S4, ALU-class opcodes SHALL drive rd=1; STO SHALL drive datactl_ena=1; JMP SHALL drive load_pc=1; SKZ with zero=1 SHALL drive inc_pc=1.
REQ-016 In S5, ALU-class opcodes SHALL drive rd=1 and load_acc=1; STO SHALL drive wr=1 and datactl_ena=1; JMP SHALL drive load_pc=1; SKZ with zero=1 SHALL drive inc_pc=1.
REQ-017 In S6, STO SHALL drive datactl_ena=1; all other strobes SHALL be 0.
REQ-018 In S7, all strobes SHALL be 0, and the next state SHALL be S0.
REQ-019 SKZ with zero=0 SHALL produce no strobes in S4-S7; SKZ with zero=1 SHALL produce exactly two inc_pc cycles, skipping one 2-byte instruction.
REQ-020 The zero input SHALL be sampled combinationally in S4 and S5 independently; a change of zero between S4 and S5 SHALL be reflected in that cycle.
REQ-021 Once halted=1, the state SHALL freeze at S3, halt SHALL remain 1, all other strobes SHALL be 0, and ena and opcode SHALL be ignored until reset.
REQ-022 The block SHALL never assert rd and wr in the same cycle, and SHALL never assert wr without datactl_ena.
REQ-023 The block SHALL drive phase equal to the state register at all times.

Reset
REQ-024 When rst=0, the block SHALL asynchronously set state=S0 and halted=0, and SHALL force all strobes to 0 regardless of ena.
REQ-025 When rst is released, the block SHALL resume from S0; with ena=1, load_ir SHALL assert in the first cycle after release.
REQ-026 Reset asserted mid-instruction, such as in S5 during STO, SHALL drop wr and datactl_ena in the same cycle without waiting for clk1.

Verification
REQ-027 The bench SHALL cover LDA: ena=1, opcode=101 -> load_ir/rd/inc_pc in S0-S1, rd in S4, rd+load_acc in S5, 8 cycles total, phase 0..7..0.
REQ-028 The bench SHALL cover STO: opcode=110 -> datactl_ena in S4-S6, wr only in S5, rd=0 throughout S4-S6.
REQ-029 The bench SHALL cover SKZ: opcode=001 with zero=1 -> inc_pc in S0, S1, S4 and S5 (4 pulses); repeated with zero=0 -> 2 pulses.
REQ-030 The bench SHALL cover HLT: opcode=000 -> halt=1 from S3 on; phase stays 3 for 20+ cycles with ena toggling; rst=0 then 1 -> halt=0, phase=0.
REQ-031 The bench SHALL cover ena deasserted in S4 during JMP -> phase=0 at the next edge and load_pc=0 thereafter; re-enabling restarts the fetch at S0.
REQ-032 The bench SHALL cover asynchronous reset between clk1 edges in S5 during ADD -> load_acc and rd fall immediately and phase=0 before the next edge.
